decode_instruction_queue: RTL

Buffering stage directly downstream of the decode unit. It accepts one decoded instruction per cycle from the decode mux output, holds up to `depth` entries in program order, and presents the oldest entry to dispatch with a valid/ready handshake. Decode has no ready input, so the block raises `stall_o` early enough to absorb every instruction already in flight through the three decode stages.

---
 rtl/decode_instruction_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/decode_instruction_queue.sv
// Decoded-instruction queue between decode and dispatch.
// Circular buffer of packed entries, oldest entry presented with valid/ready.
// stall_o leaves enough room for instructions still in flight through decode.
module decode_instruction_queue #(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned opcodeSize              = 12,
    parameter int unsigned funcUnitCodeSize        = 3,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned instMinIdWidth          = 7,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned regAccessPatternSize    = 2,
    parameter int unsigned bodyWidth               = 84,
    parameter int unsigned depth                   = 8,
    parameter int unsigned stallReserve            = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [24:0]                        instFormat_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            address_i,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic [instMinIdWidth-1:0]          minID_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic [regAccessPatternSize-1:0]    op3rw_i,
    input  logic [regAccessPatternSize-1:0]    op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic [bodyWidth-1:0]               body_i,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic [24:0]                        instFormat_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            address_o,
    output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
    output logic [instructionCounterWidth-1:0] majID_o,
    output logic [instMinIdWidth-1:0]          minID_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic [regAccessPatternSize-1:0]    op3rw_o,
    output logic [regAccessPatternSize-1:0]    op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [bodyWidth-1:0]               body_o,
    output logic                               stall_o,
    output logic [$clog2(depth):0]             count_o,
    output logic                               overflow_o
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EntryWidth = 25 + opcodeSize + addressWidth + funcUnitCodeSize
                                       + instructionCounterWidth + instMinIdWidth + 1 + PidSize
                                       + TidSize + 4 * regAccessPatternSize + 4 + bodyWidth;
    localparam logic [CW-1:0] DepthC   = CW'(depth);
    localparam logic [CW-1:0] LastPtr  = CW'(depth - 1);
    localparam logic [CW-1:0] ReserveC = CW'(stallReserve);

    logic [EntryWidth-1:0] mem [depth];
    logic [EntryWidth-1:0] wr_entry;
    logic [EntryWidth-1:0] head_entry;

    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_d;
    logic          stall_q, stall_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign wr_entry = {instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
                       is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
                       op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i};

    assign full    = (count_q == DepthC);
    assign valid_o = (count_q != '0);
    assign do_pop  = valid_o && ready_i && !flush_i;
    assign do_push = enable_i && (!full || do_pop) && !flush_i;

    // Next-state for pointers, occupancy, stall and sticky overflow.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
            // A push into a full queue without a pop is dropped.
            if (enable_i && full && !do_pop) begin
                overflow_d = 1'b1;
            end
        end
        free_d  = DepthC - count_d;
        stall_d = flush_i ? 1'b0 : (free_d <= ReserveC);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Head fields read 0 whenever the queue is empty.
    always_comb begin
        head_entry = '0;
        if (valid_o) begin
            head_entry = mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
            is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
            op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o} = head_entry;

    assign stall_o    = stall_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
